// File: rtl/pipelined_shift_unit.sv
// Elastic, multi-stage barrel shifter/rotator for EX (LSL, LSR, ASR, ROR).
// Produces carry/zero flags, passes a destination tag through, and supports flush.
module pipelined_shift_unit #(
    parameter int DataWidth = 16,
    parameter int ShAmtBits = 4,
    parameter int Stages    = 2,
    parameter int TagWidth  = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    input  logic [ShAmtBits-1:0] in_shamt,
    input  logic [1:0]           in_mode,
    input  logic [TagWidth-1:0]  in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data,
    output logic                 out_carry,
    output logic                 out_zero,
    output logic [TagWidth-1:0]  out_tag
);

    localparam int Lvls = ShAmtBits / Stages;

    typedef logic [DataWidth-1:0] word_t;
    typedef logic [ShAmtBits-1:0] shamt_t;
    typedef logic [TagWidth-1:0]  tag_t;
    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } mode_e;

    logic   valid_q [Stages];
    word_t  data_q  [Stages];
    shamt_t shamt_q [Stages];
    mode_e  mode_q  [Stages];
    logic   carry_q [Stages];
    logic   zero_q  [Stages];
    tag_t   tag_q   [Stages];

    logic   adv       [Stages];
    logic   src_valid [Stages];
    word_t  src_data  [Stages];
    shamt_t src_shamt [Stages];
    mode_e  src_mode  [Stages];
    logic   src_carry [Stages];
    tag_t   src_tag   [Stages];
    word_t  nxt_data  [Stages];

    function automatic word_t shift_level(word_t d, mode_e m, int j);
        word_t r;
        int    sh;
        sh = 1 << j;
        unique case (m)
            LSL: r = d << sh;
            LSR: r = d >> sh;
            ASR: r = word_t'($signed(d) >>> sh);
            ROR: r = (d >> sh) | (d << (DataWidth - sh));
        endcase
        return r;
    endfunction

    // ROR's result MSB equals in[s-1], so it shares the right-shift carry tap.
    function automatic logic entry_carry(word_t d, shamt_t s, mode_e m);
        shamt_t idx;
        if (s == '0) begin
            return 1'b0;
        end
        idx = (m == LSL) ? (~s + 1'b1) : (s - 1'b1);
        return d[idx];
    endfunction

    always_comb begin
        logic a;
        a = !valid_q[Stages-1] || out_ready;
        adv[Stages-1] = a;
        for (int k = Stages - 2; k >= 0; k--) begin
            a = !valid_q[k] || a;
            adv[k] = a;
        end
    end

    assign in_ready = RST && !flush && adv[0];

    always_comb begin
        src_valid[0] = in_valid && in_ready;
        src_data[0]  = in_data;
        src_shamt[0] = in_shamt;
        src_mode[0]  = mode_e'(in_mode);
        src_carry[0] = entry_carry(in_data, in_shamt, mode_e'(in_mode));
        src_tag[0]   = in_tag;
        for (int k = 1; k < Stages; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_shamt[k] = shamt_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_carry[k] = carry_q[k-1];
            src_tag[k]   = tag_q[k-1];
        end
    end

    always_comb begin
        shamt_t bits;
        for (int k = 0; k < Stages; k++) begin
            nxt_data[k] = src_data[k];
            for (int l = 0; l < Lvls; l++) begin
                bits = src_shamt[k] >> (k * Lvls + l);
                if (bits[0]) begin
                    nxt_data[k] = shift_level(nxt_data[k], src_mode[k], k * Lvls + l);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int k = 0; k < Stages; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                mode_q[k]  <= LSL;
                carry_q[k] <= 1'b0;
                zero_q[k]  <= 1'b0;
                tag_q[k]   <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < Stages; k++) begin
                valid_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < Stages; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        data_q[k]  <= nxt_data[k];
                        shamt_q[k] <= src_shamt[k];
                        mode_q[k]  <= src_mode[k];
                        carry_q[k] <= src_carry[k];
                        zero_q[k]  <= (nxt_data[k] == '0);
                        tag_q[k]   <= src_tag[k];
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[Stages-1];
    assign out_data  = data_q[Stages-1];
    assign out_carry = carry_q[Stages-1];
    assign out_zero  = zero_q[Stages-1];
    assign out_tag   = tag_q[Stages-1];

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Scoreboard bench for pipelined_shift_unit: default 16-bit/2-stage unit plus
// 32-bit units with 5 stages and 1 stage checked against a reference model.
module tb_pipelined_shift_unit;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  s;
        logic [1:0]  m;
        logic [2:0]  t;
        logic [15:0] ed;
        logic        ec;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic [2:0]  t;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic        i1_valid, i1_ready, o1_valid, o1_ready, o1_carry, o1_zero;
    logic [15:0] i1_data, o1_data;
    logic [3:0]  i1_shamt;
    logic [1:0]  i1_mode;
    logic [2:0]  i1_tag, o1_tag;

    logic        i2_valid, i2_ready, o2_valid, o2_ready, o2_carry, o2_zero;
    logic [31:0] i2_data, o2_data;
    logic [4:0]  i2_shamt;
    logic [1:0]  i2_mode;
    logic [2:0]  i2_tag, o2_tag;

    logic        i3_valid, i3_ready, o3_valid, o3_ready, o3_carry, o3_zero;
    logic [31:0] i3_data, o3_data;
    logic [4:0]  i3_shamt;
    logic [1:0]  i3_mode;
    logic [2:0]  i3_tag, o3_tag;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    exp_t e1, e2, e3;
    vec_t dir[$];
    vec_t bp[$];

    pipelined_shift_unit u_dut1 (
        .CLK(clk), .RST(rst_n), .flush(flush),
        .in_valid(i1_valid), .in_ready(i1_ready), .in_data(i1_data),
        .in_shamt(i1_shamt), .in_mode(i1_mode), .in_tag(i1_tag),
        .out_valid(o1_valid), .out_ready(o1_ready), .out_data(o1_data),
        .out_carry(o1_carry), .out_zero(o1_zero), .out_tag(o1_tag)
    );

    pipelined_shift_unit #(
        .DataWidth(32), .ShAmtBits(5), .Stages(5), .TagWidth(3)
    ) u_dut2 (
        .CLK(clk), .RST(rst_n), .flush(1'b0),
        .in_valid(i2_valid), .in_ready(i2_ready), .in_data(i2_data),
        .in_shamt(i2_shamt), .in_mode(i2_mode), .in_tag(i2_tag),
        .out_valid(o2_valid), .out_ready(o2_ready), .out_data(o2_data),
        .out_carry(o2_carry), .out_zero(o2_zero), .out_tag(o2_tag)
    );

    pipelined_shift_unit #(
        .DataWidth(32), .ShAmtBits(5), .Stages(1), .TagWidth(3)
    ) u_dut3 (
        .CLK(clk), .RST(rst_n), .flush(1'b0),
        .in_valid(i3_valid), .in_ready(i3_ready), .in_data(i3_data),
        .in_shamt(i3_shamt), .in_mode(i3_mode), .in_tag(i3_tag),
        .out_valid(o3_valid), .out_ready(o3_ready), .out_data(o3_data),
        .out_carry(o3_carry), .out_zero(o3_zero), .out_tag(o3_tag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Bit-by-bit reference: returns {carry, result}.
    function automatic logic [32:0] ref_shift(logic [31:0] d, int s, logic [1:0] m);
        logic [31:0] o;
        logic        c;
        for (int i = 0; i < 32; i++) begin
            case (m)
                2'd0: o[i] = (i >= s) ? d[i-s] : 1'b0;
                2'd1: o[i] = (i + s < 32) ? d[i+s] : 1'b0;
                2'd2: o[i] = (i + s < 32) ? d[i+s] : d[31];
                default: o[i] = d[(i+s)%32];
            endcase
        end
        if (s == 0) c = 1'b0;
        else if (m == 2'd3) c = o[31];
        else if (m == 2'd0) c = d[32-s];
        else c = d[s-1];
        return {c, o};
    endfunction

    always @(negedge clk) begin
        if (rst_n && o1_valid && o1_ready) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_output", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("d1_result", {o1_data, o1_carry, o1_zero, o1_tag},
                    {e1.d[15:0], e1.c, e1.d[15:0] == 16'h0, e1.t});
                if (e1.lat) chk("d1_latency", cyc - e1.acc, 2);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && o2_valid && o2_ready) begin
            if (q2.size() == 0) begin
                chk("d2_unexpected_output", 1, 0);
            end else begin
                e2 = q2.pop_front();
                chk("d2_result", {o2_data, o2_carry, o2_zero, o2_tag},
                    {e2.d, e2.c, e2.d == 32'h0, e2.t});
                if (e2.lat) chk("d2_latency", cyc - e2.acc, 5);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && o3_valid && o3_ready) begin
            if (q3.size() == 0) begin
                chk("d3_unexpected_output", 1, 0);
            end else begin
                e3 = q3.pop_front();
                chk("d3_result", {o3_data, o3_carry, o3_zero, o3_tag},
                    {e3.d, e3.c, e3.d == 32'h0, e3.t});
                if (e3.lat) chk("d3_latency", cyc - e3.acc, 1);
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic apply1(input vec_t v);
        i1_data  = v.d;
        i1_shamt = v.s;
        i1_mode  = v.m;
        i1_tag   = v.t;
    endtask

    task automatic push1(input vec_t v, input bit lat);
        q1.push_back('{d: 32'(v.ed), c: v.ec, t: v.t, acc: cyc, lat: lat});
    endtask

    task automatic send1(input vec_t v, input bit push, input bit lat);
        bit ok;
        ok = 1'b0;
        apply1(v);
        i1_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (i1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("d1_accept_timeout", 1, 0);
        else if (push) push1(v, lat);
        @(posedge clk);
        #1;
        i1_valid = 1'b0;
    endtask

    task automatic send32(input int which, input logic [31:0] d, input logic [4:0] s,
                          input logic [1:0] m, input logic [2:0] t,
                          input logic [31:0] ed, input logic ec, input bit lat);
        bit ok;
        ok = 1'b0;
        if (which == 2) begin
            i2_data = d; i2_shamt = s; i2_mode = m; i2_tag = t; i2_valid = 1'b1;
        end else begin
            i3_data = d; i3_shamt = s; i3_mode = m; i3_tag = t; i3_valid = 1'b1;
        end
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if ((which == 2) ? i2_ready : i3_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("d32_accept_timeout", 1, 0);
        else if (which == 2) q2.push_back('{d: ed, c: ec, t: t, acc: cyc, lat: lat});
        else q3.push_back('{d: ed, c: ec, t: t, acc: cyc, lat: lat});
        @(posedge clk);
        #1;
        i2_valid = 1'b0;
        i3_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (q1.size() + q2.size() + q3.size() == 0) return;
        end
        chk("drain_timeout", 1, 0);
    endtask

    task automatic rand_run(input int which, input int nops);
        logic [32:0] r;
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  m;
        logic [2:0]  t;
        logic        v;
        int          sent;
        bit          took;
        sent = 0;
        v = 1'b1; d = $urandom; s = 5'($urandom_range(0, 31));
        m = 2'($urandom_range(0, 3)); t = 3'($urandom_range(0, 7));
        for (int n = 0; n < 20000 && sent < nops; n++) begin
            if (which == 2) begin
                i2_valid = v; i2_data = d; i2_shamt = s; i2_mode = m; i2_tag = t;
            end else begin
                i3_valid = v; i3_data = d; i3_shamt = s; i3_mode = m; i3_tag = t;
            end
            @(negedge clk);
            took = v && ((which == 2) ? i2_ready : i3_ready);
            if (took) begin
                r = ref_shift(d, int'(s), m);
                if (which == 2) q2.push_back('{d: r[31:0], c: r[32], t: t, acc: cyc, lat: 1'b0});
                else q3.push_back('{d: r[31:0], c: r[32], t: t, acc: cyc, lat: 1'b0});
                sent++;
            end
            @(posedge clk);
            #1;
            o2_ready = ($urandom_range(0, 3) != 0);
            o3_ready = ($urandom_range(0, 3) != 0);
            if (took || !v) begin
                v = ($urandom_range(0, 4) != 0);
                d = $urandom; s = 5'($urandom_range(0, 31));
                m = 2'($urandom_range(0, 3)); t = 3'($urandom_range(0, 7));
            end
        end
        chk("rand_ops_sent", sent, nops);
        i2_valid = 1'b0; i3_valid = 1'b0;
        o2_ready = 1'b1; o3_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc_n;
        vec_t fv;

        dir.push_back('{16'hFFFA, 4'd1,  2'd0, 3'd2, 16'hFFF4, 1'b1});
        dir.push_back('{16'hFFF4, 4'd3,  2'd0, 3'd3, 16'hFFA0, 1'b1});
        dir.push_back('{16'h8000, 4'd15, 2'd2, 3'd4, 16'hFFFF, 1'b0});
        dir.push_back('{16'h8000, 4'd15, 2'd1, 3'd5, 16'h0001, 1'b0});
        dir.push_back('{16'h0001, 4'd1,  2'd3, 3'd6, 16'h8000, 1'b1});
        dir.push_back('{16'h1234, 4'd0,  2'd0, 3'd0, 16'h1234, 1'b0});
        dir.push_back('{16'h1234, 4'd0,  2'd1, 3'd1, 16'h1234, 1'b0});
        dir.push_back('{16'h1234, 4'd0,  2'd2, 3'd2, 16'h1234, 1'b0});
        dir.push_back('{16'h1234, 4'd0,  2'd3, 3'd3, 16'h1234, 1'b0});
        dir.push_back('{16'h0001, 4'd1,  2'd1, 3'd7, 16'h0000, 1'b1});
        dir.push_back('{16'h00F0, 4'd8,  2'd3, 3'd1, 16'hF000, 1'b1});
        dir.push_back('{16'h8001, 4'd1,  2'd0, 3'd2, 16'h0002, 1'b1});
        dir.push_back('{16'h1234, 4'd4,  2'd3, 3'd3, 16'h4123, 1'b0});
        dir.push_back('{16'hF000, 4'd4,  2'd2, 3'd4, 16'hFF00, 1'b0});
        dir.push_back('{16'h00FF, 4'd4,  2'd1, 3'd5, 16'h000F, 1'b1});

        bp.push_back('{16'h0011, 4'd4, 2'd0, 3'd1, 16'h0110, 1'b0});
        bp.push_back('{16'h0100, 4'd8, 2'd1, 3'd2, 16'h0001, 1'b0});
        bp.push_back('{16'h8421, 4'd1, 2'd3, 3'd3, 16'hC210, 1'b1});
        bp.push_back('{16'h7FFF, 4'd3, 2'd2, 3'd4, 16'h0FFF, 1'b1});

        rst_n = 1'b0; flush = 1'b0;
        i1_valid = 1'b1; apply1(dir[0]); o1_ready = 1'b1;
        i2_valid = 1'b0; i2_data = '0; i2_shamt = '0; i2_mode = '0; i2_tag = '0; o2_ready = 1'b1;
        i3_valid = 1'b0; i3_data = '0; i3_shamt = '0; i3_mode = '0; i3_tag = '0; o3_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", i1_ready, 0);
        chk("rst_outputs", {o1_valid, o1_data, o1_carry, o1_zero, o1_tag}, 0);
        chk("rst_outputs_32", {o2_valid, o2_data, o2_zero, o3_valid, o3_data, o3_zero}, 0);
        align();
        rst_n = 1'b1;
        i1_valid = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", i1_ready, 1);

        align();
        foreach (dir[i]) send1(dir[i], 1'b1, i == 0);
        drain();

        align();
        o1_ready = 1'b0;
        acc_n = 0;
        apply1(bp[0]);
        i1_valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (i1_ready) begin
                push1(bp[acc_n], 1'b0);
                acc_n++;
            end
            @(posedge clk);
            #1;
            if (acc_n < 4) apply1(bp[acc_n]);
        end
        chk("bp_accepted_when_stalled", acc_n, 2);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("bp_in_ready_low", i1_ready, 0);
            chk("bp_outputs_hold", {o1_valid, o1_data, o1_carry, o1_zero, o1_tag},
                {1'b1, bp[0].ed, bp[0].ec, 1'b0, bp[0].t});
        end
        align();
        o1_ready = 1'b1;
        for (int n = 0; n < 20 && acc_n < 4; n++) begin
            @(negedge clk);
            if (n == 0) chk("bp_deliver_and_accept", {i1_ready, o1_valid}, 2'b11);
            if (i1_ready) begin
                push1(bp[acc_n], 1'b0);
                acc_n++;
            end
            @(posedge clk);
            #1;
            if (acc_n < 4) apply1(bp[acc_n]);
            else i1_valid = 1'b0;
        end
        chk("bp_all_accepted", acc_n, 4);
        drain();

        align();
        o1_ready = 1'b0;
        send1(bp[0], 1'b0, 1'b0);
        send1(bp[1], 1'b0, 1'b0);
        apply1(bp[2]);
        i1_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready_low", i1_ready, 0);
        align();
        flush = 1'b0;
        i1_valid = 1'b0;
        o1_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid_low", o1_valid, 0);
        align();
        fv = '{16'h0003, 4'd14, 2'd0, 3'd6, 16'hC000, 1'b0};
        send1(fv, 1'b1, 1'b1);
        drain();

        align();
        o1_ready = 1'b0;
        send1(bp[3], 1'b0, 1'b0);
        rst_n = 1'b0;
        align();
        rst_n = 1'b1;
        o1_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("midrst_outputs", {o1_valid, o1_data, o1_carry, o1_zero, o1_tag}, 0);
        end

        align();
        send32(2, 32'h8000_0000, 5'd31, 2'd2, 3'd5, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send32(3, 32'h8000_0000, 5'd31, 2'd2, 3'd6, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send32(2, 32'h0000_0001, 5'd31, 2'd0, 3'd1, 32'h8000_0000, 1'b0, 1'b0);
        send32(3, 32'h8000_0001, 5'd1,  2'd3, 3'd2, 32'hC000_0000, 1'b1, 1'b0);
        drain();

        align();
        rand_run(2, 1000);
        drain();
        align();
        rand_run(3, 500);
        drain();

        chk("scoreboard_empty", q1.size() + q2.size() + q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipelined_shift_unit.md
Name: pipelined_shift_unit

Overview:
- Parametrised, pipelined shift/rotate execution unit for the Pipelined_Processor datapath.
- Generalises the single-mode immediate left shift (LSI) to four modes, configurable data width and configurable pipeline depth.
- Adds carry/zero flag outputs, a destination-tag passthrough, valid/ready backpressure and a squash (flush) input.
- Sits in EX, fed by decode with operand, shift amount, mode and destination register tag.

Parameters:
- DataWidth, 16, operand/result width in bits; power of two, at least 8.
- ShAmtBits, 4, shift amount width; must equal log2(DataWidth).
- Stages, 2, number of pipeline register stages; must divide ShAmtBits. Each stage implements ShAmtBits/Stages barrel levels.
- TagWidth, 3, destination register tag width (matches RegAddrBits).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-low.
- flush  input  1  synchronous squash of all in-flight operations.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit accepts the operation this cycle.
- in_data  input  DataWidth  operand.
- in_shamt  input  ShAmtBits  shift amount, 0..DataWidth-1.
- in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_tag  input  TagWidth  destination register tag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  DataWidth  shifted result.
- out_carry  output  1  last bit shifted out; for ROR, result MSB.
- out_zero  output  1  out_data == 0.
- out_tag  output  TagWidth  tag of the result.

Behaviour:
- Reset (RST=0 at a rising edge): all stage valid bits cleared; all stage data, flag and tag registers cleared to 0. Outputs reset to out_valid=0, out_data=0, out_carry=0, out_zero=0, out_tag=0.
- in_ready is combinational and is 0 while RST=0.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Deliver when out_valid && out_ready.
- Elastic pipeline:
  - Stage k advances when it is empty, or when stage k+1 is advancing or empty.
  - The last stage advances when out_ready=1.
  - in_ready = stage 0 empty || stage 0 advancing.
- Latency: an operation accepted at edge N presents out_valid=1 after edge N+Stages-1 with no stall. Throughput is 1 operation per cycle.
- Stall: while out_ready=0, out_valid, out_data, out_carry, out_zero and out_tag hold stable. Upstream stages fill until all Stages slots are occupied, then in_ready=0.
- Arithmetic (s = in_shamt):
  - LSL: out = in << s; zero fill.
  - LSR: out = in >> s; zero fill.
  - ASR: out = in >> s; fill with in[DataWidth-1].
  - ROR: out = in rotated right by s.
- Carry:
  - s=0: carry=0 in all modes.
  - LSL: in[DataWidth-s].
  - LSR and ASR: in[s-1].
  - ROR: out[DataWidth-1].
  - Carry may be computed in stage 0 and carried along the pipeline.
- Level split: barrel level j (shift by 2^j) lives in stage floor(j / (ShAmtBits/Stages)). The shift amount and mode travel with the data.
- Flush: at the edge where flush=1, all valid bits are cleared. in_ready is forced to 0 that cycle, so an operation offered with flush=1 is not accepted. Flush takes precedence over accept and deliver. Output registers may retain stale data, but out_valid=0.
- Reset mid-operation: equivalent to flush plus clearing all data. No partial result is ever delivered.
- Simultaneous deliver and accept on a full pipeline: permitted. Occupancy is unchanged and no bubble is inserted.
- Pipeline contents are never dropped or duplicated; ordering is strictly FIFO.

Test Plan:
- Reset hold: RST=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0 and all outputs 0. After RST=1, in_ready=1 on the next cycle.
- LSL chain (defaults), out_ready=1:
  - (0xFFFA, 1, LSL, tag 2) -> out_data=0xFFF4, carry=1, zero=0, tag=2, exactly Stages cycles after accept.
  - (0xFFF4, 3, LSL, tag 3) -> 0xFFA0, carry=1.
- Modes:
  - 0x8000 ASR 15 -> 0xFFFF, carry=0.
  - 0x8000 LSR 15 -> 0x0001, carry=0.
  - 0x0001 ROR 1 -> 0x8000, carry=1.
  - 0x1234 any mode with shamt 0 -> 0x1234, carry=0.
  - 0x0001 LSR 1 -> 0x0000, zero=1, carry=1.
- Backpressure:
  - out_ready=0 while offering 4 back-to-back ops -> exactly Stages ops accepted, then in_ready=0.
  - Outputs hold stable through the stall.
  - Releasing out_ready delivers all ops in order with no loss or duplication. On a full pipeline, a deliver and an accept in the same cycle are both observed.
- Flush: 2 ops in flight, assert flush for 1 cycle together with in_valid=1 -> out_valid=0 next cycle, the offered op is not accepted, and the next op completes normally with correct data.
- Parameter sweep: DataWidth=32, ShAmtBits=5, Stages=5 and Stages=1 -> 0x80000000 ASR 31 = 0xFFFFFFFF, latency equals Stages, randomized compare against a reference model for 1000 ops.
